// File: rtl/answer_checker_if.sv
// Bus between the phrase generator/keypad side and the answer checker.
// Carries the round request, player keys, second tick and verdict outputs.
// No backpressure; every strobe is consumed or dropped in the cycle it arrives.
interface answer_checker_if;
  logic        gen_done;
  logic [13:0] result;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        sec_pulse;
  logic        ready;
  logic [13:0] entry;
  logic [4:0]  time_left;
  logic        check_done;
  logic        correct;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over;

  modport master (
    output gen_done, result, key_valid, key_code, sec_pulse,
    input  ready, entry, time_left, check_done, correct, score, lives, game_over
  );

  modport slave (
    input  gen_done, result, key_valid, key_code, sec_pulse,
    output ready, entry, time_left, check_done, correct, score, lives, game_over
  );
endinterface

// File: rtl/answer_checker.sv
// Quiz answer checker: collects typed digits, times the round, scores the verdict.
// Latency: enter at edge k -> check_done/correct after k+1, ready after k+2.
// No backpressure; keys outside ENTRY and all inputs in OVER are dropped.
module answer_checker #(
  parameter int TIME_LIMIT = 20,
  parameter int MAX_LIVES  = 3
) (
  input logic             tick,
  input logic             reset_n,
  answer_checker_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, RESULT, OVER} state_t;

  state_t      state_q;
  logic [13:0] exp_q;
  logic [13:0] entry_q;
  logic [2:0]  cnt_q;
  logic [4:0]  time_q;
  logic        check_done_q;
  logic        correct_q;
  logic        timeout_q;
  logic [7:0]  score_q;
  logic [1:0]  lives_q;
  logic        game_over_q;
  logic        ready_q;
  logic        gen_q;
  // Set once gen_done has been seen low since reset, so a level that was
  // already high when reset was released cannot look like a rising edge.
  logic        armed_q;

  logic        gen_rise;
  logic        is_digit;
  logic        is_clear;
  logic        is_enter;
  logic [13:0] entry_x10;
  logic        verdict;

  assign gen_rise  = bus.gen_done && !gen_q && armed_q;
  assign is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
  assign is_clear  = bus.key_valid && (bus.key_code == 4'hA);
  assign is_enter  = bus.key_valid && (bus.key_code == 4'hE);
  // entry is capped at four digits, so entry*10 + d always fits in 14 bits
  assign entry_x10 = (entry_q << 3) + (entry_q << 1);
  assign verdict   = !timeout_q && (entry_q == exp_q);

  // Round FSM with all outputs registered alongside the state
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      entry_q      <= '0;
      cnt_q        <= '0;
      time_q       <= '0;
      check_done_q <= 1'b0;
      correct_q    <= 1'b0;
      timeout_q    <= 1'b0;
      score_q      <= '0;
      lives_q      <= 2'(MAX_LIVES);
      game_over_q  <= 1'b0;
      ready_q      <= 1'b1;
      gen_q        <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      gen_q        <= bus.gen_done;
      armed_q      <= armed_q | !bus.gen_done;
      check_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gen_rise) begin
            exp_q     <= bus.result;
            entry_q   <= '0;
            cnt_q     <= '0;
            time_q    <= 5'(TIME_LIMIT);
            correct_q <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= ENTRY;
          end
        end
        ENTRY: begin
          if (bus.sec_pulse && time_q != 5'd0)
            time_q <= time_q - 5'd1;
          if (is_digit) begin
            if (cnt_q < 3'd4) begin
              entry_q <= entry_x10 + {10'd0, bus.key_code};
              cnt_q   <= cnt_q + 3'd1;
            end
          end else if (is_clear) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end
          // enter beats an expiring second in the same cycle
          if (is_enter) begin
            timeout_q <= 1'b0;
            state_q   <= CHECK;
          end else if (bus.sec_pulse && time_q == 5'd1) begin
            timeout_q <= 1'b1;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          correct_q    <= verdict;
          check_done_q <= 1'b1;
          if (verdict) begin
            if (score_q != 8'hFF)
              score_q <= score_q + 8'd1;
          end else begin
            lives_q <= lives_q - 2'd1;
          end
          if (!verdict && lives_q == 2'd1) begin
            game_over_q <= 1'b1;
            state_q     <= OVER;
          end else begin
            state_q <= RESULT;
          end
        end
        RESULT: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        OVER: begin
          state_q <= OVER;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.entry      = entry_q;
  assign bus.time_left  = time_q;
  assign bus.check_done = check_done_q;
  assign bus.correct    = correct_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: doc/answer_checker.md
ANSWER_CHECKER -- requirements
Module: answer_checker

Interface
REQ-001 The block SHALL have parameter TIME_LIMIT, default 20, giving the seconds allowed per round (range 1-31).
REQ-002 The block SHALL have parameter MAX_LIVES, default 3, giving the wrong answers allowed before game over (range 1-3).
REQ-003 tick  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 gen_done  in  1  level from the generator; the rising edge means result is valid.
REQ-006 result  in  14  unsigned expected answer, 0-9999.
REQ-007 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-008 key_code  in  4  0-9 = digit, 4'hA = clear, 4'hE = enter; other codes are ignored.
REQ-009 sec_pulse  in  1  one-cycle strobe, once per second.
REQ-010 ready  out  1  high in IDLE; requests the next phrase.
REQ-011 entry  out  14  value the player has typed so far.
REQ-012 time_left  out  5  seconds remaining in the current round.
REQ-013 check_done  out  1  one-cycle pulse when a verdict is issued.
REQ-014 correct  out  1  verdict; valid while check_done is high, held until the next round.
REQ-015 score  out  8  count of correct answers.
REQ-016 lives  out  2  lives remaining.
REQ-017 game_over  out  1  high in OVER.

Function
REQ-018 The FSM SHALL use states IDLE, ENTRY, CHECK, RESULT and OVER.
REQ-019 IDLE: on a gen_done rising edge (registered previous value 0, current 1), the block SHALL latch result into exp_q, clear entry and digit count to 0, load time_left = TIME_LIMIT, clear correct, and go to ENTRY.
REQ-020 In IDLE, a gen_done that was already high on exit from reset or RESULT SHALL NOT start a round; only a new rising edge does.
REQ-021 ENTRY, digit d with digit count < 4: entry <= entry*10 + d, count +1; with count = 4, the digit SHALL be ignored (entry never exceeds 9999).
REQ-022 ENTRY, clear key: entry and count SHALL go to 0; time_left is unchanged.
REQ-023 ENTRY, enter key: the block SHALL go to CHECK with timeout_q = 0.
REQ-024 ENTRY, sec_pulse: time_left SHALL decrement by 1; if it goes from 1 to 0, the block SHALL go to CHECK with timeout_q = 1.
REQ-025 If enter and the expiring sec_pulse occur in the same cycle, enter SHALL win (timeout_q = 0), and time_left SHALL still decrement.
REQ-026 Keys arriving outside ENTRY SHALL be ignored.
REQ-027 CHECK (one cycle): the verdict SHALL be v = !timeout_q && (entry == exp_q); correct <= v and check_done <= 1; on v, score +1 saturating at 255; on !v, lives -1.
REQ-028 CHECK SHALL go to OVER if !v and lives == 1, otherwise to RESULT.
REQ-029 RESULT (one cycle): check_done SHALL return to 0, and the FSM SHALL go to IDLE.
REQ-030 OVER: the FSM SHALL stay in OVER until reset, with game_over = 1 and all inputs ignored.
REQ-031 check_done SHALL be high for exactly one cycle, even on the transition into OVER.
REQ-032 Latency: with enter sampled at edge k, check_done and correct SHALL be high after edge k+1, and ready SHALL be high after edge k+2.
REQ-033 The multiply-by-10 SHALL be computed as (entry<<3)+(entry<<1) at 14 bits; no overflow is possible under REQ-021.

Reset
REQ-034 While reset_n = 0, the block SHALL be asynchronously forced to: state IDLE, entry 0, digit count 0, exp_q 0, time_left 0, check_done 0, correct 0, timeout_q 0, score 0, lives = MAX_LIVES, game_over 0, gen_done edge register 0.
REQ-035 Reset asserted mid-round SHALL abandon the round with no verdict pulse.
REQ-036 After reset_n rises, the block SHALL need a fresh gen_done rising edge to start a round.

Verification
REQ-037 Result 123, keys 1,2,3,E -> check_done pulse two edges after E, correct = 1, score 0 -> 1, lives 3.
REQ-038 Result 42, keys 4,1,E -> correct = 0, lives 3 -> 2, score unchanged; then keys 9,9,9,9,9 in the next round -> entry = 9999 (fifth digit ignored).
REQ-039 TIME_LIMIT = 2, no keys, two sec_pulses -> time_left 2 -> 1 -> 0, verdict wrong, lives decrement; in a second case, enter and the second sec_pulse in the same cycle with entry = result -> correct = 1.
REQ-040 MAX_LIVES = 3, three wrong rounds -> lives 0, one check_done pulse on the third verdict, game_over = 1; later gen_done edges and keys leave everything unchanged until reset.
REQ-041 Keys 7,A,5,E with result 5 -> correct = 1; reset_n pulsed low mid-entry -> IDLE, score 0, lives 3, no check_done, ready = 1 with gen_done held high.
